// File: rtl/alu_issue_ctrl.sv
// ALU issue/capture controller: registers operands and op, waits ALU_WAIT/MULDIV_WAIT settle cycles, latches result.
// Latency start->res_valid is WAIT cycles; start is ignored while busy and the result is held until res_ready.
module alu_issue_ctrl #(
    parameter int ALU_WAIT    = 1,
    parameter int MULDIV_WAIT = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [4:0]  op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] alu_y,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    input  logic [63:0] alu_c,
    output logic [31:0] z_hi,
    output logic [31:0] z_lo,
    output logic        wide,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] ALU_CNT    = 4'(ALU_WAIT - 1);
    localparam logic [3:0] MULDIV_CNT = 4'(MULDIV_WAIT - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [4:0]  cap_op, cap_op_nxt;
    logic [4:0]  alu_op_nxt;
    logic [31:0] alu_y_nxt, alu_b_nxt, z_hi_nxt, z_lo_nxt;
    logic        wide_nxt, err_nxt;
    logic        op_legal, op_muldiv, cap_muldiv;

    assign op_legal   = op inside {[5'd3:5'd11], 5'd15, 5'd16, 5'd17, 5'd18};
    assign op_muldiv  = (op == 5'd15) || (op == 5'd16);
    assign cap_muldiv = (cap_op == 5'd15) || (cap_op == 5'd16);

    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            cnt    <= '0;
            cap_op <= '0;
            alu_op <= '0;
            alu_y  <= '0;
            alu_b  <= '0;
            z_hi   <= '0;
            z_lo   <= '0;
            wide   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            cap_op <= cap_op_nxt;
            alu_op <= alu_op_nxt;
            alu_y  <= alu_y_nxt;
            alu_b  <= alu_b_nxt;
            z_hi   <= z_hi_nxt;
            z_lo   <= z_lo_nxt;
            wide   <= wide_nxt;
            err    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cap_op_nxt = cap_op;
        alu_op_nxt = alu_op;
        alu_y_nxt  = alu_y;
        alu_b_nxt  = alu_b;
        z_hi_nxt   = z_hi;
        z_lo_nxt   = z_lo;
        wide_nxt   = wide;
        err_nxt    = 1'b0;
        case (state)
            IDLE: begin
                alu_op_nxt = '0;
                if (start) begin
                    if (op_legal) begin
                        alu_y_nxt  = a_in;
                        alu_b_nxt  = b_in;
                        alu_op_nxt = op;
                        cap_op_nxt = op;
                        cnt_nxt    = op_muldiv ? MULDIV_CNT : ALU_CNT;
                        state_nxt  = EXEC;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    // Single-word ops leave garbage in the ALU high half; never let it reach z_hi.
                    z_lo_nxt   = alu_c[31:0];
                    z_hi_nxt   = cap_muldiv ? alu_c[63:32] : 32'h0;
                    wide_nxt   = cap_muldiv;
                    alu_op_nxt = '0;
                    state_nxt  = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: behavioural ALU drives alu_c, expected results are queued at issue
// and a negedge monitor pops them whenever res_valid rises.
module tb_alu_issue_ctrl;

    localparam int AW = 1;
    localparam int MW = 4;

    bit          clk = 1'b0;
    logic        clr, start, res_ready;
    logic [4:0]  op;
    logic [31:0] a_in, b_in;
    logic [31:0] alu_y, alu_b, z_hi, z_lo;
    logic [4:0]  alu_op;
    logic [63:0] alu_c;
    logic        wide, res_valid, busy, err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          s;
        int          due;
        logic [4:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        wide;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    bit          exp_err[int];
    bit          rv_prev = 1'b0;
    logic [31:0] last_hi = 0, last_lo = 0, last_a = 0, last_b = 0;
    logic        last_wide = 0;
    logic [4:0]  legal_ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                                    5'd15, 5'd16, 5'd17, 5'd18};

    alu_issue_ctrl #(.ALU_WAIT(AW), .MULDIV_WAIT(MW)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .alu_y(alu_y), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
        .z_hi(z_hi), .z_lo(z_lo), .wide(wide), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: single-word ops deliberately pollute the high half.
    function automatic logic [63:0] alu_fn(input logic [4:0] o, input logic [31:0] y, input logic [31:0] b);
        logic [4:0]  sh;
        logic [63:0] r;
        sh = b[4:0];
        r  = 64'h0;
        case (o)
            5'd3:  r = {32'hDEADBEEF, y + b};
            5'd4:  r = {32'hDEADBEEF, y - b};
            5'd5:  r = {32'hDEADBEEF, y & b};
            5'd6:  r = {32'hDEADBEEF, y | b};
            5'd7:  r = {32'hDEADBEEF, y >> sh};
            5'd8:  r = {32'hDEADBEEF, 32'($signed(y) >>> sh)};
            5'd9:  r = {32'hDEADBEEF, y << sh};
            5'd10: r = {32'hDEADBEEF, (sh == 5'd0) ? y : ((y >> sh) | (y << (6'd32 - {1'b0, sh})))};
            5'd11: r = {32'hDEADBEEF, (sh == 5'd0) ? y : ((y << sh) | (y >> (6'd32 - {1'b0, sh})))};
            5'd15: r = {32'h0, y} * {32'h0, b};
            5'd16: r = (b == 32'h0) ? 64'h0 : {y % b, y / b};
            5'd17: r = {32'hDEADBEEF, -b};
            5'd18: r = {32'hDEADBEEF, ~b};
            default: r = 64'hFFFF_0000_FFFF_0000;
        endcase
        return r;
    endfunction

    assign alu_c = alu_fn(alu_op, alu_y, alu_b);

    function automatic bit is_legal(input logic [4:0] o);
        return (o >= 5'd3 && o <= 5'd11) || (o >= 5'd15 && o <= 5'd18);
    endfunction

    function automatic bit is_wide(input logic [4:0] o);
        return (o == 5'd15) || (o == 5'd16);
    endfunction

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (sbq.size() > 0 && cyc >= sbq[0].s && cyc < sbq[0].due) begin
            check("exec_alu_op", 64'(alu_op), 64'(sbq[0].op));
            check("exec_alu_y", 64'(alu_y), 64'(sbq[0].a));
            check("exec_alu_b", 64'(alu_b), 64'(sbq[0].b));
            check("exec_busy", 64'(busy), 64'd1);
            check("exec_no_valid", 64'(res_valid), 64'd0);
        end else if (!busy || res_valid) begin
            check("alu_op_outside_exec", 64'(alu_op), 64'd0);
        end
        if (res_valid && !rv_prev) begin
            if (sbq.size() == 0) begin
                check("unexpected_result", 64'(res_valid), 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("result_latency", 64'(cyc), 64'(mon_e.due));
                check("z_hi", 64'(z_hi), 64'(mon_e.hi));
                check("z_lo", 64'(z_lo), 64'(mon_e.lo));
                check("wide", 64'(wide), 64'(mon_e.wide));
            end
        end
        if (err || exp_err.exists(cyc)) check("err_pulse", 64'(err), 64'(exp_err.exists(cyc)));
        rv_prev = (res_valid === 1'b1);
    end

    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] r;
        @(posedge clk); #1;
        start = 1'b1; op = o; a_in = a; b_in = b;
        r      = alu_fn(o, a, b);
        e.s    = cyc + 2;
        e.due  = e.s + (is_wide(o) ? MW : AW);
        e.op   = o;
        e.a    = a;
        e.b    = b;
        e.wide = is_wide(o);
        e.lo   = r[31:0];
        e.hi   = is_wide(o) ? r[63:32] : 32'h0;
        sbq.push_back(e);
        last_hi = e.hi; last_lo = e.lo; last_wide = e.wide; last_a = a; last_b = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_result(input bit noise);
        bit ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            op    = 5'($urandom_range(0, 31));
            a_in  = $urandom;
            b_in  = $urandom;
        end
        if (!ok) begin
            check("result_timeout", 64'(res_valid), 64'd1);
            sbq.delete();
        end
    endtask

    task automatic handshake(input int stall, input int nop);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            start = (nop >= 0) ? ((i % 2) == 0) : 1'($urandom_range(0, 1));
            op    = (nop >= 0) ? 5'(nop) : 5'($urandom_range(0, 31));
            a_in  = $urandom;
            b_in  = $urandom;
            @(negedge clk);
            check("stall_valid", 64'(res_valid), 64'd1);
            check("stall_busy", 64'(busy), 64'd1);
            check("stall_z_lo", 64'(z_lo), 64'(last_lo));
            check("stall_z_hi", 64'(z_hi), 64'(last_hi));
        end
        @(posedge clk); #1;
        start = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("post_hs_busy", 64'(busy), 64'd0);
        check("post_hs_valid", 64'(res_valid), 64'd0);
        check("post_hs_z", {31'h0, wide, z_lo}, {31'h0, last_wide, last_lo});
        check("post_hs_z_hi", 64'(z_hi), 64'(last_hi));
    endtask

    task automatic illegal(input logic [4:0] o, input int n);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            start = 1'b1; op = o; a_in = $urandom; b_in = $urandom;
            exp_err[cyc + 2] = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("illegal_busy", 64'(busy), 64'd0);
            check("illegal_z_lo", 64'(z_lo), 64'(last_lo));
            check("illegal_alu_y", 64'(alu_y), 64'(last_a));
            check("illegal_alu_b", 64'(alu_b), 64'(last_b));
        end
    endtask

    task automatic check_all_zero(input string nm);
        check(nm, {alu_y, alu_b}, 64'd0);
        check(nm, {z_hi, z_lo}, 64'd0);
        check(nm, {56'd0, alu_op, wide, res_valid, busy}, 64'd0);
        check(nm, 64'(err), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] o;
        clr = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check_all_zero("reset_state");

        issue(5'd3, 32'd5, 32'd7);
        wait_result(1'b0);
        handshake(0, -1);

        issue(5'd15, 32'h0001_0000, 32'h0001_0000);
        wait_result(1'b0);
        handshake(2, -1);

        issue(5'd16, 32'd17, 32'd5);
        wait_result(1'b0);
        handshake(1, -1);

        issue(5'd5, 32'hF0F0_1234, 32'h0FF0_FFFF);
        wait_result(1'b1);
        handshake(0, -1);

        illegal(5'd0, 1);

        issue(5'd3, 32'd100, 32'd23);
        wait_result(1'b0);
        handshake(10, 4);

        // Abort a mul on its second EXEC cycle.
        issue(5'd15, 32'h1234_5678, 32'h9ABC_DEF0);
        @(posedge clk); #1;
        clr = 1'b1;
        sbq.delete();
        @(posedge clk); #1;
        clr = 1'b0;
        last_hi = 0; last_lo = 0; last_wide = 0; last_a = 0; last_b = 0;
        @(negedge clk);
        check_all_zero("clr_mid_exec");
        repeat (8) begin
            @(negedge clk);
            check("dropped_no_valid", 64'(res_valid), 64'd0);
        end

        issue(5'd3, 32'd5, 32'd7);
        wait_result(1'b0);
        handshake(0, -1);

        illegal(5'd31, 2);

        for (int n = 0; n < 40; n++) begin
            issue(legal_ops[$urandom_range(0, 12)], $urandom, $urandom);
            wait_result(1'b1);
            handshake($urandom_range(0, 4), -1);
            if ($urandom_range(0, 3) == 0) begin
                do o = 5'($urandom_range(0, 31)); while (is_legal(o));
                illegal(o, $urandom_range(1, 2));
            end
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
